// File: rtl/down_counter_timer_if.sv
// Control and status bundle for the loadable down-counter timer.
// The master issues load/decrement strobes, and the slave reports the count and flags.
interface down_counter_timer_if #(
    parameter int WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             dec;
    logic             reload_en;
    logic [WIDTH-1:0] O;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output load, load_value, dec, reload_en,
        input  O, zero, busy, done
    );

    modport slave (
        input  load, load_value, dec, reload_en,
        output O, zero, busy, done
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse and optional auto-reload.
// The count only reaches 0 in IDLE, so the decrement can never wrap.
module down_counter_timer #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    down_counter_timer_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_value;
    logic             done_q;

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            count        <= INIT;
            reload_value <= '0;
            state        <= IDLE;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                // A load wins over dec and cancels any terminal event in this cycle.
                count        <= bus.load_value;
                reload_value <= bus.load_value;
                state        <= (bus.load_value != '0) ? RUN : IDLE;
            end else if (state == RUN && bus.dec) begin
                if (count == WIDTH'(1)) begin
                    done_q <= 1'b1;
                    if (bus.reload_en) begin
                        count <= reload_value;
                    end else begin
                        count <= '0;
                        state <= IDLE;
                    end
                end else begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

    assign bus.O    = count;
    assign bus.zero = (count == '0);
    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: reset, one-shot, stall, auto-reload, priority, async abort.
module tb_down_counter_timer;
    localparam int WIDTH = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errs;

    down_counter_timer_if #(.WIDTH(WIDTH)) bus ();

    down_counter_timer #(.WIDTH(WIDTH), .INIT('0)) dut (
        .CLK         (clk),
        .ASYNCRESETN (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        bus.load       = 1'b1;
        bus.load_value = v;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        logic [4:0] stall_dec;
        logic [4:0] stall_done;
        logic [WIDTH-1:0] stall_o [5];

        n_checks = 0;
        n_errs   = 0;
        bus.load       = 1'b0;
        bus.load_value = '0;
        bus.dec        = 1'b0;
        bus.reload_en  = 1'b0;

        // Reset held across several edges
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_O", 32'(bus.O), 0);
        check("rst_zero", 32'(bus.zero), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        #2 rst_n = 1'b1;

        // dec in IDLE is ignored
        bus.dec = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_dec_O", 32'(bus.O), 0);
            check("idle_dec_done", 32'(bus.done), 0);
        end
        bus.dec = 1'b0;

        // One-shot from 5
        do_load(16'd5);
        check("os_load_O", 32'(bus.O), 5);
        check("os_load_busy", 32'(bus.busy), 1);
        bus.dec = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            tick();
            check("os_O", 32'(bus.O), 32'(i));
            check("os_done", 32'(bus.done), (i == 0) ? 32'd1 : 32'd0);
            check("os_busy", 32'(bus.busy), (i == 0) ? 32'd0 : 32'd1);
            check("os_zero", 32'(bus.zero), (i == 0) ? 32'd1 : 32'd0);
        end
        bus.dec = 1'b0;
        tick();
        check("os_done_pulse_len", 32'(bus.done), 0);

        // Stall pattern 1,0,0,1,1 from 3
        stall_dec  = 5'b11001;
        stall_done = 5'b10000;
        stall_o[0] = 16'd2; stall_o[1] = 16'd2; stall_o[2] = 16'd2;
        stall_o[3] = 16'd1; stall_o[4] = 16'd0;
        do_load(16'd3);
        check("st_load_O", 32'(bus.O), 3);
        for (int i = 0; i < 5; i++) begin
            bus.dec = stall_dec[i];
            tick();
            check("st_O", 32'(bus.O), 32'(stall_o[i]));
            check("st_done", 32'(bus.done), 32'(stall_done[i]));
        end
        bus.dec = 1'b0;

        // Auto-reload from 2
        bus.reload_en = 1'b1;
        do_load(16'd2);
        check("ar_load_O", 32'(bus.O), 2);
        bus.dec = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ar_O", 32'(bus.O), (i % 2 == 0) ? 32'd1 : 32'd2);
            check("ar_done", 32'(bus.done), (i % 2 == 0) ? 32'd0 : 32'd1);
            check("ar_busy", 32'(bus.busy), 1);
        end
        bus.dec       = 1'b0;
        bus.reload_en = 1'b0;

        // Load beats dec, including in the terminal cycle
        do_load(16'd4);
        bus.dec = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            tick();
            check("pr_O", 32'(bus.O), 32'(i));
        end
        do_load(16'd9);
        check("pr_term_load_O", 32'(bus.O), 9);
        check("pr_term_load_done", 32'(bus.done), 0);
        check("pr_term_load_busy", 32'(bus.busy), 1);
        do_load(16'd0);
        check("pr_load0_O", 32'(bus.O), 0);
        check("pr_load0_busy", 32'(bus.busy), 0);
        check("pr_load0_done", 32'(bus.done), 0);
        check("pr_load0_zero", 32'(bus.zero), 1);
        tick();
        check("pr_no_underflow_O", 32'(bus.O), 0);
        check("pr_no_underflow_done", 32'(bus.done), 0);
        bus.dec = 1'b0;

        // load_value alone has no effect
        bus.load_value = 16'd77;
        tick();
        check("lv_noload_O", 32'(bus.O), 0);

        // Reload value 1 with dec held: done every cycle
        bus.reload_en = 1'b1;
        do_load(16'd1);
        check("b2b_load_O", 32'(bus.O), 1);
        bus.dec = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b2b_O", 32'(bus.O), 1);
            check("b2b_done", 32'(bus.done), 1);
        end
        bus.dec       = 1'b0;
        bus.reload_en = 1'b0;
        do_load(16'd0);

        // Async reset mid-run
        do_load(16'd100);
        bus.dec = 1'b1;
        repeat (10) tick();
        check("ar_mid_O", 32'(bus.O), 90);
        #2 rst_n = 1'b0;
        #1;
        check("arst_O", 32'(bus.O), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_done", 32'(bus.done), 0);
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst_post_O", 32'(bus.O), 0);
            check("arst_post_done", 32'(bus.done), 0);
        end
        bus.dec = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end
endmodule
